alu_ctrl_md: RTL and testbench
==============================

Name: alu_ctrl_md

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Keeps the combinational funct/ALUOp to 4-bit ALU control decode for the datapath ALU.
- Adds an iterative multi-cycle multiply/divide sequencer with HI/LO result registers and a stall output.
- Sits beside the main ALU in the execute stage; the control path holds the PC/pipeline while stall is high.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (legal 8..64, even).
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inst_f  input  6  instruction funct field.
- alu_op  input  2  ALUOp from main control.
- issue  input  1  instruction valid in execute this cycle.
- op_a  input  WIDTH  rs operand (dividend / multiplicand).
- op_b  input  WIDTH  rt operand (divisor / multiplier).
- alu_ctrl  output  4  ALU control code (combinational).
- md_busy  output  1  sequencer running (registered).
- md_done  output  1  one-cycle pulse: HI/LO just updated.
- stall  output  1  hold pipeline; equals md_busy OR md_start (combinational).
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Decode (combinational, fully specified, no latches):
  - alu_op 00 -> 0010; 01 -> 0110; 11 -> 0010.
  - alu_op 10, by funct: 100000 add 0010; 100010 sub 0110; 011000 mult 1111; 011010 div 1110; 100100 and 0000; 100101 or 0001; 100111 nor 1100; 101010 slt 0111; any other funct -> 0010.
- md_start = issue & alu_op==10 & funct is a mult/div code & state==IDLE.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE: on md_start, latch |op_a|, |op_b|, the result signs and the op type; count <= WIDTH-1; go to MUL or DIV.
  - MUL: one shift-add step per cycle over a 2*WIDTH accumulator; at count==0 go to FIX; otherwise count decrements.
  - DIV: one restoring step per cycle (remainder WIDTH+1 bits, quotient WIDTH bits); at count==0 go to FIX.
  - FIX: apply sign correction.
    - Product is negated if signs differ.
    - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a), truncating toward zero.
    - Next state is DONE.
  - DONE: write hi/lo, pulse md_done, return to IDLE.
- Latency: md_done is high in the cycle after exactly WIDTH+2 rising edges following the issuing edge. hi/lo change on that same edge and on no other.
- md_busy: 0 in IDLE, 1 in MUL/DIV/FIX/DONE.
- Mult result: hi = upper WIDTH bits, lo = lower WIDTH bits of the signed 2*WIDTH product.
- Div result: lo = quotient, hi = remainder.
- Divide by zero: the sequencer still runs full latency, then writes lo = all ones, hi = op_a (original signed value).
- Most-negative / -1 divide: lo = most-negative value, hi = 0, no trap.
- Issue of any mult/div while busy: ignored, no restart, stall stays high; the pipeline re-presents the instruction after done.
- Non-md instructions while busy: decode still valid, stall still high.
- Reset (async, any time including mid-operation): state IDLE, count 0, hi=0, lo=0, md_busy=0, md_done=0; the aborted operation is discarded.

Optional Feature:
- Macro: ALU_CTRL_UNSIGNED_EN.
- Defined: funct 011001 multu -> 1101 and 011011 divu -> 1011. Both start the sequencer with sign handling bypassed (operands zero-extended, FIX performs no negation); same latency. Divu by zero gives lo = all ones, hi = op_a.
- Undefined: 011001/011011 decode to the default 0010 and never assert md_start.

Test Plan:
- Decode sweep: all alu_op values and all listed functs -> exact codes above; unlisted funct 000000 with alu_op 10 -> 0010; stall 0 throughout.
- WIDTH=32, mult op_a=7, op_b=0xFFFFFFFD -> after 34 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB, md_done high exactly one cycle, md_busy high 34 cycles.
- div op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then div 100/0 -> lo=0xFFFFFFFF, hi=0x00000064.
- Second mult issued 5 cycles into a div -> ignored; final hi/lo are the div result; stall continuous until done.
- rst_n pulsed low at cycle 10 of a mult (mid-cycle, asynchronous) -> outputs immediately 0, no md_done; a fresh mult 3*4 afterward gives lo=12, hi=0.
- With ALU_CTRL_UNSIGNED_EN: multu 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE. Without it: same funct gives alu_ctrl=0010 and md_busy stays 0.

Source files
------------

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decoder plus an iterative multiply/divide sequencer
// with HI/LO result registers and a pipeline stall output.
// Optional feature macro: ALU_CTRL_UNSIGNED_EN (adds multu/divu decode and
// unsigned sequencing). With the macro undefined, those functs decode to add.
module alu_ctrl_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       inst_f,
  input  logic [1:0]       alu_op,
  input  logic             issue,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_ctrl,
  output logic             md_busy,
  output logic             md_done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
`ifdef ALU_CTRL_UNSIGNED_EN
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] acc_reg;      // mult: {upper, multiplier/low}; div: low half is dividend/quotient
  logic [WIDTH:0]     rem_reg;      // restoring-division partial remainder
  logic [WIDTH-1:0]   mag_reg;      // |multiplicand| or |divisor|
  logic               neg_a_reg;
  logic               neg_b_reg;
  logic               op_mul_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               done_reg;

  logic               md_mul, md_div, md_uns, md_start;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH+1:0]   div_shift, div_trial;
  logic [WIDTH:0]     div_rem_next;
  logic               div_q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, lo_fix;
  logic [2*WIDTH-1:0] fix_val;

  // ALU control decode and multiply/divide instruction classification
  always_comb begin
    alu_ctrl = 4'b0010;
    md_mul   = 1'b0;
    md_div   = 1'b0;
    md_uns   = 1'b0;
    case (alu_op)
      2'b01: alu_ctrl = 4'b0110;
      2'b10: begin
        case (inst_f)
          F_ADD:  alu_ctrl = 4'b0010;
          F_SUB:  alu_ctrl = 4'b0110;
          F_MULT: begin alu_ctrl = 4'b1111; md_mul = 1'b1; end
          F_DIV:  begin alu_ctrl = 4'b1110; md_div = 1'b1; end
          F_AND:  alu_ctrl = 4'b0000;
          F_OR:   alu_ctrl = 4'b0001;
          F_NOR:  alu_ctrl = 4'b1100;
          F_SLT:  alu_ctrl = 4'b0111;
`ifdef ALU_CTRL_UNSIGNED_EN
          F_MULTU: begin alu_ctrl = 4'b1101; md_mul = 1'b1; md_uns = 1'b1; end
          F_DIVU:  begin alu_ctrl = 4'b1011; md_div = 1'b1; md_uns = 1'b1; end
`endif
          default: alu_ctrl = 4'b0010;
        endcase
      end
      default: alu_ctrl = 4'b0010;
    endcase
  end

  assign md_start = issue & (md_mul | md_div) & (state_reg == S_IDLE);
  assign md_busy  = (state_reg != S_IDLE);
  assign stall    = md_busy | md_start;
  assign md_done  = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

  // Operand magnitudes and per-cycle shift-add / restoring-divide / sign-fix arithmetic
  always_comb begin
    sgn_a = ~md_uns & op_a[WIDTH-1];
    sgn_b = ~md_uns & op_b[WIDTH-1];
    abs_a = sgn_a ? -op_a : op_a;
    abs_b = sgn_b ? -op_b : op_b;

    // Shift-add: add multiplicand into the upper half when the current multiplier bit is set
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mag_reg} : {(WIDTH+1){1'b0}});
    mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide: shift in next dividend bit, keep the trial difference if non-negative
    div_shift = {rem_reg, acc_reg[WIDTH-1]};
    div_trial = div_shift - {2'b00, mag_reg};
    if (!div_trial[WIDTH+1]) begin
      div_rem_next = div_trial[WIDTH:0];
      div_q_bit    = 1'b1;
    end else begin
      div_rem_next = div_shift[WIDTH:0];
      div_q_bit    = 1'b0;
    end

    // Sign correction; with a zero divisor the remainder is |a| so rem_fix restores op_a
    prod_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg : acc_reg;
    quot_fix = (neg_a_reg ^ neg_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem_fix  = neg_a_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    lo_fix   = (mag_reg == '0) ? {WIDTH{1'b1}} : quot_fix;
    fix_val  = op_mul_reg ? prod_fix : {rem_fix, lo_fix};
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Sequencer next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (md_start) state_next = md_mul ? S_MUL : S_DIV;
      S_MUL:  if (count_reg == '0) state_next = S_FIX;
      S_DIV:  if (count_reg == '0) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration, fix-up and HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      acc_reg    <= '0;
      rem_reg    <= '0;
      mag_reg    <= '0;
      neg_a_reg  <= 1'b0;
      neg_b_reg  <= 1'b0;
      op_mul_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (md_start) begin
            count_reg  <= CNT_W'(WIDTH - 1);
            neg_a_reg  <= sgn_a;
            neg_b_reg  <= sgn_b;
            op_mul_reg <= md_mul;
            rem_reg    <= '0;
            if (md_mul) begin
              mag_reg <= abs_a;
              acc_reg <= {{WIDTH{1'b0}}, abs_b};
            end else begin
              mag_reg <= abs_b;
              acc_reg <= {{WIDTH{1'b0}}, abs_a};
            end
          end
        end
        S_MUL: begin
          acc_reg <= mul_step;
          if (count_reg != '0) count_reg <= count_reg - CNT_W'(1);
        end
        S_DIV: begin
          acc_reg[WIDTH-1:0] <= {acc_reg[WIDTH-2:0], div_q_bit};
          rem_reg            <= div_rem_next;
          if (count_reg != '0) count_reg <= count_reg - CNT_W'(1);
        end
        S_FIX: acc_reg <= fix_val;
        S_DONE: begin
          hi_reg   <= acc_reg[2*WIDTH-1:WIDTH];
          lo_reg   <= acc_reg[WIDTH-1:0];
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Testbench for alu_ctrl_md (WIDTH=32): decode sweep, directed and random
// mult/div against a plain-arithmetic reference, busy-issue, async reset.
module tb_alu_ctrl_md;
  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   inst_f = '0;
  logic [1:0]   alu_op = '0;
  logic         issue = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [3:0]   alu_ctrl;
  logic         md_busy, md_done, stall;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  alu_ctrl_md #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .inst_f(inst_f), .alu_op(alu_op), .issue(issue),
    .op_a(op_a), .op_b(op_b), .alu_ctrl(alu_ctrl), .md_busy(md_busy),
    .md_done(md_done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit unsigned_en();
`ifdef ALU_CTRL_UNSIGNED_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Reference decode table
  function automatic logic [3:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b01) return 4'b0110;
    if (op != 2'b10) return 4'b0010;
    case (f)
      F_SUB:   return 4'b0110;
      F_MULT:  return 4'b1111;
      F_DIV:   return 4'b1110;
      F_AND:   return 4'b0000;
      F_OR:    return 4'b0001;
      F_NOR:   return 4'b1100;
      F_SLT:   return 4'b0111;
      F_MULTU: return unsigned_en() ? 4'b1101 : 4'b0010;
      F_DIVU:  return unsigned_en() ? 4'b1011 : 4'b0010;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic bit is_md(input logic [5:0] f);
    return (f == F_MULT) || (f == F_DIV) ||
           (unsigned_en() && ((f == F_MULTU) || (f == F_DIVU)));
  endfunction

  // Reference multiply/divide using 64-bit integer arithmetic
  task automatic ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rh, output logic [W-1:0] rl);
    bit mul, uns;
    longint sa, sb, q, r, p;
    mul = (f == F_MULT) || (f == F_MULTU);
    uns = (f == F_MULTU) || (f == F_DIVU);
    sa = uns ? longint'({32'b0, a}) : longint'($signed(a));
    sb = uns ? longint'({32'b0, b}) : longint'($signed(b));
    if (mul) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else if (b == '0) begin
      rl = '1;
      rh = a;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rl = q[31:0];
      rh = r[31:0];
    end
  endtask

  // Issue one mult/div, optionally present a second mult while busy, and check timing/result
  task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject);
    logic [W-1:0] exp_hi, exp_lo, hi0, lo0;
    int edges, busy_n, stall_n;
    bit hold_ok;
    ref_md(f, a, b, exp_hi, exp_lo);
    hi0 = hi;
    lo0 = lo;
    inst_f = f; alu_op = 2'b10; issue = 1'b1; op_a = a; op_b = b;
    #1;
    check("start_stall", {63'b0, stall}, 64'd1);
    check("idle_busy", {63'b0, md_busy}, 64'd0);
    @(posedge clk); #1;
    issue = 1'b0; alu_op = 2'b00; op_a = $urandom; op_b = $urandom;
    edges = 0; busy_n = 0; stall_n = 0; hold_ok = 1'b1;
    while (!md_done && edges < 200) begin
      if (md_busy) busy_n++;
      if (stall) stall_n++;
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
      if (edges == inject) begin
        issue = 1'b1; alu_op = 2'b10; inst_f = F_MULT; op_a = $urandom; op_b = $urandom;
        #1 check("busy_decode", {60'b0, alu_ctrl}, 64'hF);
      end else begin
        issue = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    issue = 1'b0;
    check("latency", 64'(edges), 64'(W + 2));
    check("busy_cycles", 64'(busy_n), 64'(W + 2));
    check("stall_cycles", 64'(stall_n), 64'(W + 2));
    check("hilo_hold", {63'b0, hold_ok}, 64'd1);
    check("hi", {32'b0, hi}, {32'b0, exp_hi});
    check("lo", {32'b0, lo}, {32'b0, exp_lo});
    check("busy_at_done", {63'b0, md_busy}, 64'd0);
    $display("md f=%b a=%h b=%h -> hi=%h lo=%h (exp %h %h) edges=%0d",
             f, a, b, hi, lo, exp_hi, exp_lo, edges);
    @(posedge clk); #1;
    check("done_pulse", {63'b0, md_done}, 64'd0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] functs [13];
    logic [5:0] f;
    bit seen;
    functs = '{F_ADD, F_SUB, F_MULT, F_DIV, F_AND, F_OR, F_NOR, F_SLT,
               F_MULTU, F_DIVU, 6'b000000, 6'b111111, 6'b100001};

    // Reset state
    #2;
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, md_busy}, 64'd0);
    check("rst_done", {63'b0, md_done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode sweep
    for (int op = 0; op < 4; op++) begin
      for (int i = 0; i < 13; i++) begin
        alu_op = 2'(op);
        inst_f = functs[i];
        issue  = !((op == 2) && is_md(functs[i]));
        #2;
        check("decode", {60'b0, alu_ctrl}, {60'b0, ref_ctrl(2'(op), functs[i])});
        check("decode_stall", {63'b0, stall}, 64'd0);
      end
    end
    issue = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    run_md(F_MULT, 32'd7, 32'hFFFF_FFFD, -1);
    check("spec_mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    check("spec_mult_lo", {32'b0, lo}, 64'hFFFF_FFEB);
    run_md(F_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    check("spec_div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    check("spec_div_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    run_md(F_DIV, 32'd100, 32'd0, -1);
    check("div0_lo", {32'b0, lo}, 64'hFFFF_FFFF);
    check("div0_hi", {32'b0, hi}, 64'h64);
    run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("minneg_lo", {32'b0, lo}, 64'h8000_0000);
    check("minneg_hi", {32'b0, hi}, 64'h0);
    run_md(F_DIV, 32'd1000, 32'd7, 5);
    check("inject_lo", {32'b0, lo}, 64'd142);
    check("inject_hi", {32'b0, hi}, 64'd6);

    // Asynchronous reset mid-multiply
    inst_f = F_MULT; alu_op = 2'b10; issue = 1'b1; op_a = 32'd5; op_b = 32'd9;
    @(posedge clk); #1;
    issue = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_hi", {32'b0, hi}, 64'd0);
    check("arst_lo", {32'b0, lo}, 64'd0);
    check("arst_busy", {63'b0, md_busy}, 64'd0);
    check("arst_stall", {63'b0, stall}, 64'd0);
    check("arst_done", {63'b0, md_done}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (md_done || md_busy) seen = 1'b1;
    end
    check("arst_no_done", {63'b0, seen}, 64'd0);
    run_md(F_MULT, 32'd3, 32'd4, -1);
    check("post_rst_lo", {32'b0, lo}, 64'd12);
    check("post_rst_hi", {32'b0, hi}, 64'd0);

    // Unsigned feature
`ifdef ALU_CTRL_UNSIGNED_EN
    run_md(F_MULTU, 32'hFFFF_FFFF, 32'd2, -1);
    check("multu_hi", {32'b0, hi}, 64'd1);
    check("multu_lo", {32'b0, lo}, 64'hFFFF_FFFE);
    run_md(F_DIVU, 32'hFFFF_FFF0, 32'd0, -1);
    run_md(F_DIVU, 32'hFFFF_FFF0, 32'd7, -1);
`else
    inst_f = F_MULTU; alu_op = 2'b10; issue = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'd2;
    #1;
    check("multu_off_ctrl", {60'b0, alu_ctrl}, 64'h2);
    check("multu_off_stall", {63'b0, stall}, 64'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (md_busy) seen = 1'b1;
    end
    check("multu_off_busy", {63'b0, seen}, 64'd0);
    issue = 1'b0;
    @(posedge clk); #1;
`endif

    // Random mult/div
    for (int k = 0; k < 16; k++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_DIV;
        2: f = unsigned_en() ? F_MULTU : F_MULT;
        default: f = unsigned_en() ? F_DIVU : F_DIV;
      endcase
      run_md(f, pick_operand(), pick_operand(), (k % 4 == 0) ? 3 : -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
